// File: rtl/vga_cfg_pkg.sv
// Shared definitions for the vga_clock SPI configuration loader:
// register map of the vga_clock core, boot table contents and the
// frame-sequencer state encoding.
package vga_cfg_pkg;

  localparam logic [7:0] REG_COLOUR_HRS = 8'h00;
  localparam logic [7:0] REG_COLOUR_MIN = 8'h01;
  localparam logic [7:0] REG_COLOUR_SEC = 8'h02;
  localparam logic [7:0] REG_COLOUR_BG  = 8'h03;

  // Room for the largest supported table; only the first NUM_BOOT entries are sent.
  localparam int BOOT_MAX = 16;

  localparam logic [7:0] BOOT_ADDR [BOOT_MAX] = '{
    REG_COLOUR_HRS, REG_COLOUR_MIN, REG_COLOUR_SEC, REG_COLOUR_BG,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] BOOT_DATA [BOOT_MAX] = '{
    8'h30, 8'h0C, 8'h03, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/spi_frame_shifter.sv
// 16-bit SPI mode-0 frame sequencer: divider, bit counter and shift register.
// A frame is accepted with load while ready is high (IDLE, or the last GAP
// cycle so back-to-back frames need no idle cycle).
// Optional readback: VGA_CFG_READBACK_EN adds cipo sampling of bits 7..0.
//
// state | meaning
// IDLE  | csb high, sck low, waiting for load
// SETUP | csb low, first bit on copi, one half-period before the first rise
// SHIFT | 16 bits, each sck high then low for one half-period
// GAP   | csb high, copi low for CSB_GAP half-periods
module spi_frame_shifter
  import vga_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CSB_GAP = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] frame,
  output logic        ready,
  output logic        idle,
  output logic        last_cycle,
  output logic        busy,
  output logic        sck,
  output logic        csb,
`ifdef VGA_CFG_READBACK_EN
  output logic        gap_entry,
  input  logic        cipo,
  output logic [7:0]  rd_data,
`endif
  output logic        copi
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int GAP_W = $clog2(CSB_GAP) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CSB_GAP - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      sr_q, sr_d;
  logic             sck_q, sck_d, csb_q, csb_d, copi_q, copi_d, busy_q, busy_d;
  logic             div_tc, gap_tc;

  assign div_tc     = (div_q == '0);
  assign gap_tc     = (gap_q == '0);
  assign idle       = (state_q == ST_IDLE);
  assign last_cycle = (state_q == ST_GAP) && div_tc && gap_tc;
  assign ready      = idle || last_cycle;
  assign busy       = busy_q;
  assign sck        = sck_q;
  assign csb        = csb_q;
  assign copi       = copi_q;

  // Registered state and SPI pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sck_q   <= 1'b0;
      csb_q   <= 1'b1;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sck_q   <= sck_d;
      csb_q   <= csb_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: half-period timing, bit stepping, frame start
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sck_d   = sck_q;
    csb_d   = csb_q;
    copi_d  = copi_q;
    case (state_q)
      ST_SETUP: begin
        if (div_tc) begin
          state_d = ST_SHIFT;
          div_d   = DIV_LOAD;
          sck_d   = 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!div_tc) begin
          div_d = div_q - 1'b1;
        end else if (sck_q) begin
          // falling edge: present the next bit
          sck_d  = 1'b0;
          div_d  = DIV_LOAD;
          sr_d   = {sr_q[14:0], 1'b0};
          copi_d = sr_q[14];
        end else if (bit_q == 4'd0) begin
          state_d = ST_GAP;
          csb_d   = 1'b1;
          copi_d  = 1'b0;
          div_d   = DIV_LOAD;
          gap_d   = GAP_LOAD;
        end else begin
          sck_d = 1'b1;
          div_d = DIV_LOAD;
          bit_d = bit_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (!div_tc) begin
          div_d = div_q - 1'b1;
        end else if (!gap_tc) begin
          gap_d = gap_q - 1'b1;
          div_d = DIV_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
    if (load && ready) begin
      state_d = ST_SETUP;
      div_d   = DIV_LOAD;
      bit_d   = 4'd15;
      sr_d    = frame;
      csb_d   = 1'b0;
      sck_d   = 1'b0;
      copi_d  = frame[15];
    end
    busy_d = (state_d != ST_IDLE);
  end

`ifdef VGA_CFG_READBACK_EN
  logic [7:0] rd_data_q;
  assign rd_data   = rd_data_q;
  assign gap_entry = (state_q == ST_SHIFT) && div_tc && !sck_q && (bit_q == 4'd0);

  // Shift in the slave reply on the rising edges that clock bits 7..0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rd_data_q <= '0;
    else if ((state_q == ST_SHIFT) && div_tc && !sck_q && (bit_q != 4'd0) && (bit_q <= 4'd8))
      rd_data_q <= {rd_data_q[6:0], cipo};
  end
`endif

endmodule

// File: rtl/vga_clock_cfg_loader.sv
// SPI configuration loader for vga_clock: replays the boot table after reset
// or start, then serves single host register writes.
// Optional readback: VGA_CFG_READBACK_EN adds spi_cipo, rd_data, rd_valid.
module vga_clock_cfg_loader
  import vga_cfg_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CSB_GAP  = 2,
  parameter int NUM_BOOT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       host_req,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_data,
  output logic       host_ack,
  output logic       busy,
  output logic       boot_done,
`ifdef VGA_CFG_READBACK_EN
  input  logic       spi_cipo,
  output logic [7:0] rd_data,
  output logic       rd_valid,
`endif
  output logic       spi_sck,
  output logic       spi_csb,
  output logic       spi_copi
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_BOOT - 1);

  logic        sh_load, sh_ready, sh_idle, sh_last;
  logic [15:0] sh_frame;
  logic        load_boot, load_host;
  logic [3:0]  idx_sel;
  logic        boot_pend_q, boot_done_q, host_ack_q, cur_host_q, cur_last_boot_q;
  logic [3:0]  boot_idx_q;

  // Arbiter: a (re)boot outranks host writes; host frames start only from IDLE
  always_comb begin
    load_boot = 1'b0;
    load_host = 1'b0;
    idx_sel   = boot_idx_q;
    if (sh_idle && start) begin
      load_boot = 1'b1;
      idx_sel   = 4'd0;
    end else if (boot_pend_q && sh_ready) begin
      load_boot = 1'b1;
    end else if (sh_idle && host_req) begin
      load_host = 1'b1;
    end
  end

  assign sh_load   = load_boot || load_host;
  assign sh_frame  = load_boot ? {BOOT_ADDR[idx_sel], BOOT_DATA[idx_sel]} : {host_addr, host_data};
  assign host_ack  = host_ack_q;
  assign boot_done = boot_done_q || (cur_last_boot_q && sh_last);

  // Boot progress, frame ownership and handshake flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      boot_pend_q     <= 1'b1;
      boot_idx_q      <= 4'd0;
      boot_done_q     <= 1'b0;
      host_ack_q      <= 1'b0;
      cur_host_q      <= 1'b0;
      cur_last_boot_q <= 1'b0;
    end else begin
      host_ack_q <= load_host;
      if (sh_load) begin
        cur_host_q      <= load_host;
        cur_last_boot_q <= load_boot && (idx_sel == LAST_IDX);
      end
      if (load_boot) begin
        if (idx_sel == LAST_IDX) begin
          boot_pend_q <= 1'b0;
          boot_idx_q  <= 4'd0;
        end else begin
          boot_pend_q <= 1'b1;
          boot_idx_q  <= idx_sel + 4'd1;
        end
      end
      if (sh_idle && start)
        boot_done_q <= 1'b0;
      else if (cur_last_boot_q && sh_last)
        boot_done_q <= 1'b1;
    end
  end

`ifdef VGA_CFG_READBACK_EN
  logic sh_gap_entry, rd_valid_q;
  assign rd_valid = rd_valid_q;

  // Readback is reported for host frames only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_valid_q <= 1'b0;
    else          rd_valid_q <= sh_gap_entry && cur_host_q;
  end
`endif

  spi_frame_shifter #(
    .CLK_DIV (CLK_DIV),
    .CSB_GAP (CSB_GAP)
  ) u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (sh_load),
    .frame      (sh_frame),
    .ready      (sh_ready),
    .idle       (sh_idle),
    .last_cycle (sh_last),
    .busy       (busy),
    .sck        (spi_sck),
    .csb        (spi_csb),
`ifdef VGA_CFG_READBACK_EN
    .gap_entry  (sh_gap_entry),
    .cipo       (spi_cipo),
    .rd_data    (rd_data),
`endif
    .copi       (spi_copi)
  );

endmodule

// File: tb/tb_vga_clock_cfg_loader.sv
// Self-checking bench for vga_clock_cfg_loader (CLK_DIV=2, CSB_GAP=2, NUM_BOOT=4).
// A passive SPI slave captures complete 16-bit frames; expectations come from
// the boot table constants, random host writes and frame-length arithmetic.
module tb_vga_clock_cfg_loader;

  localparam int CD       = 2;
  localparam int CG       = 2;
  localparam int NB       = 4;
  localparam int FRAME    = CD * (1 + 32 + CG);
  localparam int CSB_LOW  = CD * 33;
  localparam int BOOT_CYC = NB * FRAME;
  localparam logic [7:0] BOOT_A [NB] = '{8'h00, 8'h01, 8'h02, 8'h03};
  localparam logic [7:0] BOOT_D [NB] = '{8'h30, 8'h0C, 8'h03, 8'h00};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, host_req;
  logic [7:0] host_addr, host_data;
  logic       host_ack, busy, boot_done, spi_sck, spi_csb, spi_copi;
`ifdef VGA_CFG_READBACK_EN
  logic       spi_cipo = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] slave_resp = 8'h00;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] frames[$];
  int          lens[$];
  logic [15:0] sh;
  int          nbits   = 0;
  int          low_cnt = 0;

  always #5 clk = ~clk;

  vga_clock_cfg_loader #(.CLK_DIV(CD), .CSB_GAP(CG), .NUM_BOOT(NB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .host_req  (host_req),
    .host_addr (host_addr),
    .host_data (host_data),
    .host_ack  (host_ack),
    .busy      (busy),
    .boot_done (boot_done),
`ifdef VGA_CFG_READBACK_EN
    .spi_cipo  (spi_cipo),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
`endif
    .spi_sck   (spi_sck),
    .spi_csb   (spi_csb),
    .spi_copi  (spi_copi)
  );

  // Slave: shift on SCK rise, keep only complete 16-bit frames at CSB rise
  always @(posedge spi_sck or posedge spi_csb) begin
    if (spi_csb) begin
      if (nbits == 16) frames.push_back(sh);
      nbits = 0;
    end else begin
      sh = {sh[14:0], spi_copi};
      nbits++;
    end
  end

  // CSB low-time measurement in clock cycles
  always @(negedge clk) begin
    if (spi_csb === 1'b0) low_cnt++;
    else begin
      if (low_cnt != 0) lens.push_back(low_cnt);
      low_cnt = 0;
    end
  end

`ifdef VGA_CFG_READBACK_EN
  // Slave reply: data byte bits 7..0 presented after each falling edge
  always @(negedge spi_sck or negedge spi_csb) begin
    if (!spi_csb && nbits >= 8 && nbits < 16) spi_cipo = slave_resp[15 - nbits];
    else spi_cipo = 1'b0;
  end
`endif

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; host_req = 1'b0; host_addr = 8'h00; host_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (spi_csb !== 1'b1) begin n_fail++; $display("FAIL reset_csb: got %b expected 1", spi_csb); end
    n_checks++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", spi_sck); end
    n_checks++; if (spi_copi !== 1'b0) begin n_fail++; $display("FAIL reset_copi: got %b expected 0", spi_copi); end
    n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", host_ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL reset_boot_done: got %b expected 0", boot_done); end
  endtask

  // Boot replay (from reset release or a start pulse) with a host write waiting behind it
  task automatic test_boot(input bit via_start, input int host_at);
    logic [7:0]  ha, hd;
    logic [15:0] exp_q[$];
    int          done_at, ack_at, extra_ack, bad_len;
    logic        busy_last, busy_after, done_k1;
    ha = 8'($urandom); hd = 8'($urandom);
    for (int i = 0; i < NB; i++) exp_q.push_back({BOOT_A[i], BOOT_D[i]});
    exp_q.push_back({ha, hd});
    frames.delete(); lens.delete();
    host_addr = ha; host_data = hd;
    done_at = -1; ack_at = -1; extra_ack = 0; bad_len = 0;
    busy_last = 1'b0; busy_after = 1'b1; done_k1 = 1'b1;
    if (via_start) begin
      start = 1'b1; host_req = 1'b1;
    end else begin
      @(negedge clk);
      reset_n = 1'b1;
    end
    for (int k = 1; k <= BOOT_CYC + FRAME + 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin start = 1'b0; done_k1 = boot_done; end
      if (!via_start && k == host_at) host_req = 1'b1;
      if (boot_done === 1'b1 && done_at < 0) done_at = k;
      if (host_ack === 1'b1) begin
        if (ack_at < 0) begin ack_at = k; host_req = 1'b0; end
        else extra_ack++;
      end
      if (k == BOOT_CYC) busy_last = busy;
      if (k == BOOT_CYC + 1) busy_after = busy;
    end
    n_checks++; if (done_k1 !== 1'b0) begin n_fail++; $display("FAIL boot_done_early: got %b expected 0", done_k1); end
    n_checks++; if (done_at != BOOT_CYC) begin n_fail++; $display("FAIL boot_done_cycle: got %0d expected %0d", done_at, BOOT_CYC); end
    n_checks++; if (ack_at != BOOT_CYC + 2) begin n_fail++; $display("FAIL queued_ack_cycle: got %0d expected %0d", ack_at, BOOT_CYC + 2); end
    n_checks++; if (extra_ack != 0) begin n_fail++; $display("FAIL ack_pulse_width: got %0d extra expected 0", extra_ack); end
    n_checks++; if (busy_last !== 1'b1) begin n_fail++; $display("FAIL busy_last_gap: got %b expected 1", busy_last); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL busy_after_boot: got %b expected 0", busy_after); end
    n_checks++;
    if (frames.size() != NB + 1) begin
      n_fail++; $display("FAIL boot_frame_count: got %0d expected %0d", frames.size(), NB + 1);
    end else begin
      for (int i = 0; i <= NB; i++) begin
        n_checks++;
        if (frames[i] !== exp_q[i]) begin n_fail++; $display("FAIL boot_frame_%0d: got %h expected %h", i, frames[i], exp_q[i]); end
      end
    end
    foreach (lens[i]) if (lens[i] != CSB_LOW) bad_len++;
    n_checks++; if (bad_len != 0 || lens.size() != NB + 1) begin n_fail++; $display("FAIL boot_csb_low: got %0d bad of %0d expected 0 of %0d", bad_len, lens.size(), NB + 1); end
  endtask

  // Random single writes from IDLE; one iteration also pulses start mid-frame
  task automatic test_host_random();
    logic [7:0] a, d;
    int lat, bsy, extra;
    bit got;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) begin a = 8'h03; d = 8'hA5; end
      else begin a = 8'($urandom); d = 8'($urandom); end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      frames.delete(); lens.delete();
      host_addr = a; host_data = d; host_req = 1'b1;
      lat = 0; bsy = 0; extra = 0; got = 1'b0;
      for (int k = 1; k <= 200; k++) begin
        @(posedge clk);
        #1;
        if (host_ack === 1'b1) begin
          if (!got) begin got = 1'b1; lat = k; host_req = 1'b0; end
          else extra++;
        end
        if (busy === 1'b1) bsy++;
        start = (n == 2 && k == 30);
        if (got && busy !== 1'b1) break;
      end
      start = 1'b0;
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL host_ack_latency[%0d]: got %0d expected 1", n, lat); end
      n_checks++; if (bsy != FRAME) begin n_fail++; $display("FAIL host_busy_len[%0d]: got %0d expected %0d", n, bsy, FRAME); end
      n_checks++; if (extra != 0) begin n_fail++; $display("FAIL host_ack_width[%0d]: got %0d extra expected 0", n, extra); end
      n_checks++;
      if (frames.size() != 1) begin n_fail++; $display("FAIL host_frame_count[%0d]: got %0d expected 1", n, frames.size()); end
      else if (frames[0] !== {a, d}) begin n_fail++; $display("FAIL host_frame[%0d]: got %h expected %h", n, frames[0], {a, d}); end
      n_checks++;
      if (lens.size() != 1 || lens[0] != CSB_LOW) begin n_fail++; $display("FAIL host_csb_low[%0d]: got %0d entries expected one of %0d", n, lens.size(), CSB_LOW); end
      n_checks++; if (boot_done !== 1'b1) begin n_fail++; $display("FAIL host_boot_done[%0d]: got %b expected 1", n, boot_done); end
    end
  endtask

  // Asynchronous reset in the middle of a host frame's SHIFT phase
  task automatic test_reset_mid_frame();
    bit got;
    int nfr;
    nfr = frames.size();
    host_addr = 8'($urandom); host_data = 8'($urandom); host_req = 1'b1; got = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(posedge clk);
      #1;
      if (host_ack === 1'b1) begin got = 1'b1; host_req = 1'b0; end
    end
    host_req = 1'b0;
    n_checks++; if (!got) begin n_fail++; $display("FAIL midreset_ack: got none expected ack within 10 cycles"); end
    repeat (3 + $urandom_range(0, 30)) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++; if (spi_csb !== 1'b1) begin n_fail++; $display("FAIL midreset_csb: got %b expected 1", spi_csb); end
    n_checks++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL midreset_sck: got %b expected 0", spi_sck); end
    n_checks++; if (spi_copi !== 1'b0) begin n_fail++; $display("FAIL midreset_copi: got %b expected 0", spi_copi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL midreset_boot_done: got %b expected 0", boot_done); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (frames.size() != nfr) begin n_fail++; $display("FAIL midreset_partial: got %0d frames expected %0d", frames.size(), nfr); end
  endtask

`ifdef VGA_CFG_READBACK_EN
  task automatic test_readback();
    logic [7:0] resp;
    int ack_at, v_at, v_cnt;
    for (int n = 0; n < 2; n++) begin
      resp = (n == 0) ? 8'h5A : 8'($urandom);
      slave_resp = resp;
      host_addr = 8'($urandom); host_data = 8'($urandom); host_req = 1'b1;
      ack_at = -1; v_at = -1; v_cnt = 0;
      for (int k = 1; k <= 200; k++) begin
        @(posedge clk);
        #1;
        if (host_ack === 1'b1 && ack_at < 0) begin ack_at = k; host_req = 1'b0; end
        if (rd_valid === 1'b1) begin v_cnt++; v_at = k; end
        if (ack_at > 0 && busy !== 1'b1) break;
      end
      host_req = 1'b0;
      n_checks++; if (v_cnt != 1) begin n_fail++; $display("FAIL rd_valid_count[%0d]: got %0d expected 1", n, v_cnt); end
      n_checks++; if (v_at != ack_at + CSB_LOW) begin n_fail++; $display("FAIL rd_valid_cycle[%0d]: got %0d expected %0d", n, v_at, ack_at + CSB_LOW); end
      n_checks++; if (rd_data !== resp) begin n_fail++; $display("FAIL rd_data[%0d]: got %h expected %h", n, rd_data, resp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_boot(1'b0, 10);
    test_host_random();
    test_boot(1'b1, 0);
    test_reset_mid_frame();
    test_boot(1'b0, $urandom_range(2, 250));
`ifdef VGA_CFG_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
